// File: rtl/huc6261_pkg.sv
// Shared types and constants for the HuC6261 palette access controller.
package huc6261_pkg;

    localparam int unsigned PAL_AW         = 9;
    localparam int unsigned PAL_DW         = 16;
    localparam int unsigned PAL_FIFO_DEPTH = 4;

    // One posted CPU write: target palette address plus colour word.
    typedef struct packed {
        logic [PAL_AW-1:0] addr;
        logic [PAL_DW-1:0] data;
    } pal_wr_t;

    // Owner of the single palette RAM port in a given CE cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_VID,
        OP_WR,
        OP_PF
    } pal_op_e;

endpackage

// File: rtl/huc6261_pal_fifo.sv
// Posted-write FIFO of pal_wr_t entries. Push while full and pop while
// empty are ignored; the caller gates both with the clock enable.
module huc6261_pal_fifo
    import huc6261_pkg::*;
#(
    parameter int unsigned DEPTH = PAL_FIFO_DEPTH
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  pal_wr_t                wdata,
    output pal_wr_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    pal_wr_t         store [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry storage; contents need no reset because count guards them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = store[rd_ptr];
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/huc6261_pal_ctrl.sv
// HuC6261 palette access controller: 512x16 single-port palette RAM shared
// between pixel fetches (always first), posted CPU writes and a CPU read
// prefetch. Optional feature macro: HUC6261_PAL_READBACK_EN enables the
// prefetch buffer, CPU_DRD and CPU_RDVALID; without it those are inert.
module huc6261_pal_ctrl
    import huc6261_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = PAL_FIFO_DEPTH
)
(
    input  logic              CLK,
    input  logic              RES,
    input  logic              CE,
    input  logic              VID_REQ,
    input  logic [PAL_AW-1:0] VID_IDX,
    output logic [PAL_DW-1:0] VID_COLOR,
    input  logic              CPU_AWR,
    input  logic              CPU_DWR,
    input  logic              CPU_DRD,
    input  logic [PAL_DW-1:0] CPU_DI,
    output logic [PAL_DW-1:0] CPU_DO,
    output logic              CPU_RDY,
    output logic              CPU_RDVALID,
    output logic              CPU_OVF,
    output logic [PAL_AW-1:0] CPU_ADDR
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [PAL_AW-1:0] cpu_addr;
    logic              ovf;
    logic              awr;
    logic              dwr;
    logic              push;
    logic              drop;
    logic              pop;
    logic              drd_take;
    pal_op_e           op;
    pal_wr_t           fifo_in;
    pal_wr_t           fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [PAL_DW-1:0] ram [0:(1<<PAL_AW)-1];
    logic [PAL_DW-1:0] ram_q;
    logic [PAL_AW-1:0] ram_addr;
    logic              vid_pend;

`ifdef HUC6261_PAL_READBACK_EN
    logic              rdvalid;
    logic              pf_pend;
    logic              pf_kill;
    logic [PAL_DW-1:0] pf_buf;
    logic [PAL_DW-1:0] do_q;
`endif

    // CPU command decode: address load beats write, write beats read.
    always_comb begin
        awr  = CE && !RES && CPU_AWR;
        dwr  = CE && !RES && CPU_DWR && !CPU_AWR;
        push = dwr && !fifo_full;
        drop = dwr && fifo_full;
    end

    // RAM port arbitration for this CE cycle: video, then FIFO pop, then prefetch.
    always_comb begin
        op = OP_IDLE;
        if (CE && !RES) begin
            if (VID_REQ) begin
                op = OP_VID;
            end else if (!fifo_empty) begin
                op = OP_WR;
`ifdef HUC6261_PAL_READBACK_EN
            end else if (!rdvalid && !pf_pend) begin
                op = OP_PF;
`endif
            end
        end
    end

    assign pop      = (op == OP_WR);
    assign ram_addr = (op == OP_VID) ? VID_IDX : cpu_addr;
    assign fifo_in  = '{addr: cpu_addr, data: CPU_DI};

    huc6261_pal_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RES),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Single-port palette RAM: one write or one registered read per CE cycle.
    always_ff @(posedge CLK) begin
        if (op == OP_WR) begin
            ram[fifo_head.addr] <= fifo_head.data;
        end else if (op != OP_IDLE) begin
            ram_q <= ram[ram_addr];
        end
    end

    // Video colour register, loaded one CE cycle after the RAM read.
    always_ff @(posedge CLK) begin
        if (RES) begin
            vid_pend  <= 1'b0;
            VID_COLOR <= '0;
        end else if (CE) begin
            vid_pend <= (op == OP_VID);
            if (vid_pend) begin
                VID_COLOR <= ram_q;
            end
        end
    end

    // CPU address register and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RES) begin
            cpu_addr <= '0;
            ovf      <= 1'b0;
        end else if (CE) begin
            if (awr) begin
                cpu_addr <= CPU_DI[PAL_AW-1:0];
                ovf      <= 1'b0;
            end else if (push || drd_take) begin
                cpu_addr <= cpu_addr + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef HUC6261_PAL_READBACK_EN
    // Any address change during a prefetch makes its data stale.
    assign pf_kill  = awr || dwr;
    assign drd_take = CE && !RES && CPU_DRD && !CPU_AWR && !CPU_DWR && rdvalid;

    // Prefetch tracking, buffer fill and CPU read consumption.
    always_ff @(posedge CLK) begin
        if (RES) begin
            pf_pend <= 1'b0;
            rdvalid <= 1'b0;
            pf_buf  <= '0;
            do_q    <= '0;
        end else if (CE) begin
            pf_pend <= (op == OP_PF) && !pf_kill;
            if (awr || push) begin
                rdvalid <= 1'b0;
            end else if (drd_take) begin
                rdvalid <= 1'b0;
                do_q    <= pf_buf;
            end else if (pf_pend && !pf_kill) begin
                rdvalid <= 1'b1;
                pf_buf  <= ram_q;
            end
        end
    end

    assign CPU_DO      = do_q;
    assign CPU_RDVALID = rdvalid;
`else
    logic unused_drd;
    assign unused_drd  = CPU_DRD;
    assign drd_take    = 1'b0;
    assign CPU_DO      = '0;
    assign CPU_RDVALID = 1'b0;
`endif

    assign CPU_RDY  = (fifo_count != CW'(FIFO_DEPTH));
    assign CPU_OVF  = ovf;
    assign CPU_ADDR = cpu_addr;

endmodule

// File: tb/tb_huc6261_pal_ctrl.sv
// Directed bench for huc6261_pal_ctrl with a behavioural palette model.
module tb_huc6261_pal_ctrl;

`ifdef HUC6261_PAL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic        CE = 1'b0;
    logic        VID_REQ = 1'b0;
    logic [8:0]  VID_IDX = '0;
    logic [15:0] VID_COLOR;
    logic        CPU_AWR = 1'b0;
    logic        CPU_DWR = 1'b0;
    logic        CPU_DRD = 1'b0;
    logic [15:0] CPU_DI = '0;
    logic [15:0] CPU_DO;
    logic        CPU_RDY;
    logic        CPU_RDVALID;
    logic        CPU_OVF;
    logic [8:0]  CPU_ADDR;

    int errors = 0;
    int checks = 0;

    huc6261_pal_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .VID_REQ(VID_REQ), .VID_IDX(VID_IDX), .VID_COLOR(VID_COLOR),
        .CPU_AWR(CPU_AWR), .CPU_DWR(CPU_DWR), .CPU_DRD(CPU_DRD),
        .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_RDY(CPU_RDY),
        .CPU_RDVALID(CPU_RDVALID), .CPU_OVF(CPU_OVF), .CPU_ADDR(CPU_ADDR)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: palette array, queue of posted writes, CPU state.
    logic [15:0] m_mem [512];
    logic [24:0] m_q [$];
    logic [8:0]  m_addr;
    bit          m_ovf, m_rdv, m_pf, m_vpend;
    logic [15:0] m_pfd, m_buf, m_do, m_color, m_vdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr = '0; m_ovf = 0; m_rdv = 0; m_pf = 0; m_vpend = 0;
        m_do = '0; m_color = '0;
    endtask

    task automatic model_step(input bit v, input logic [8:0] idx, input bit awr,
                              input bit dwr, input bit drd, input logic [15:0] di);
        bit w, accepted, kill, issue, land, take;
        logic [24:0] e;
        logic [15:0] pf_new;
        w        = dwr && !awr;
        accepted = w && (m_q.size() < DEPTH);
        kill     = awr || w;
        issue    = 0;
        pf_new   = 'x;
        if (m_vpend) m_color = m_vdata;
        m_vpend = v;
        if (v) begin
            m_vdata = m_mem[idx];
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_mem[e[24:16]] = e[15:0];
        end else if (RB && !m_rdv && !m_pf) begin
            issue  = 1;
            pf_new = m_mem[m_addr];
        end
        land = m_pf && !kill;
        take = RB && drd && !awr && !w && m_rdv;
        if (awr) begin
            m_addr = di[8:0]; m_ovf = 0; m_rdv = 0;
        end else if (w) begin
            if (accepted) begin
                m_q.push_back({m_addr, di});
                m_addr = m_addr + 9'd1;
                m_rdv = 0;
            end else begin
                m_ovf = 1;
            end
        end else if (take) begin
            m_do = m_buf; m_addr = m_addr + 9'd1; m_rdv = 0;
        end else if (land) begin
            m_rdv = 1; m_buf = m_pfd;
        end
        m_pf = issue && !kill;
        if (issue) m_pfd = pf_new;
    endtask

    task automatic compare_all();
        if (!$isunknown(m_color)) chk("vid_color", VID_COLOR, m_color);
        if (!$isunknown(m_do))    chk("cpu_do", CPU_DO, m_do);
        chk("cpu_rdy", CPU_RDY, m_q.size() < DEPTH);
        chk("cpu_rdvalid", CPU_RDVALID, m_rdv);
        chk("cpu_ovf", CPU_OVF, m_ovf);
        chk("cpu_addr", CPU_ADDR, m_addr);
    endtask

    // One CE cycle: inputs are also present across the preceding non-CE edge.
    task automatic cyc(input bit v, input logic [8:0] idx, input bit awr,
                       input bit dwr, input bit drd, input logic [15:0] di);
        VID_REQ = v; VID_IDX = idx; CPU_AWR = awr; CPU_DWR = dwr; CPU_DRD = drd; CPU_DI = di;
        CE = 1'b0;
        @(posedge CLK); #1;
        CE = 1'b1;
        @(posedge CLK); #1;
        CE = 1'b0;
        model_step(v, idx, awr, dwr, drd, di);
        VID_REQ = 0; CPU_AWR = 0; CPU_DWR = 0; CPU_DRD = 0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, '0);
    endtask
    task automatic vid(input logic [8:0] idx);  cyc(1, idx, 0, 0, 0, '0); endtask
    task automatic awr(input logic [8:0] a);    cyc(0, '0, 1, 0, 0, {7'd0, a}); endtask
    task automatic dwr(input logic [15:0] d);   cyc(0, '0, 0, 1, 0, d); endtask
    task automatic drd();                       cyc(0, '0, 0, 0, 1, '0); endtask

    initial begin
        // Reset for two CE cycles
        RES = 1'b1; CE = 1'b1;
        repeat (2) @(posedge CLK);
        #1; RES = 1'b0; CE = 1'b0;
        model_reset();
        compare_all();
        chk("reset_rdy", CPU_RDY, 1);
        chk("reset_color", VID_COLOR, 16'h0000);
        chk("reset_addr", CPU_ADDR, 9'h000);

        // Write across the address wrap, then read both back via video
        awr(9'h1FF);
        dwr(16'h1234);
        dwr(16'hABCD);
        chk("wrap_addr", CPU_ADDR, 9'h001);
        idle(2);
        vid(9'h1FF);
        idle(1);
        chk("vid_1ff", VID_COLOR, 16'h1234);
        vid(9'h000);
        chk("vid_hold", VID_COLOR, 16'h1234);
        idle(1);
        chk("vid_000", VID_COLOR, 16'hABCD);

        // Video wins over a pending pop; the pop lands on the next free cycle
        awr(9'h020);
        dwr(16'h0F0F);
        idle(1);
        awr(9'h020);
        dwr(16'h1111);
        vid(9'h020);
        idle(1);
        chk("contend_old", VID_COLOR, 16'h0F0F);
        vid(9'h020);
        idle(1);
        chk("contend_new", VID_COLOR, 16'h1111);

        // Overflow: video every cycle starves pops, six writes fill and overflow
        awr(9'h100);
        for (int k = 0; k < 6; k++) cyc(1, 9'h020, 0, 1, 0, 16'hA000 + 16'(k));
        chk("ovf_set", CPU_OVF, 1);
        chk("ovf_rdy", CPU_RDY, 0);
        chk("ovf_addr", CPU_ADDR, 9'h104);
        for (int i = 0; i < 5; i++) cyc(i == 0, 9'h020, 0, 0, 0, '0);
        chk("drain_rdy", CPU_RDY, 1);
        vid(9'h103);
        idle(1);
        chk("ovf_last_kept", VID_COLOR, 16'hA003);
        awr(9'h000);
        chk("ovf_clear", CPU_OVF, 0);

        // Readback coherence: prefetch waits for the FIFO to drain
        cyc(1, 9'h020, 1, 0, 0, 16'h000F);
        cyc(1, 9'h020, 0, 1, 0, 16'h7777);
        cyc(1, 9'h020, 0, 1, 0, 16'h5555);
        cyc(1, 9'h020, 1, 0, 0, 16'h0010);
        idle(1);
        chk("rb_wait1", CPU_RDVALID, 0);
        idle(2);
        chk("rb_wait2", CPU_RDVALID, 0);
        idle(1);
        chk("rb_valid", CPU_RDVALID, RB);
        drd();
        chk("rb_do", CPU_DO, RB ? 16'h5555 : 16'h0000);
        chk("rb_addr", CPU_ADDR, RB ? 9'h011 : 9'h010);

        // In-flight prefetch discarded by an address load
        idle(1);
        awr(9'h1FF);
        chk("pf_discard", CPU_RDVALID, 0);
        idle(2);
        chk("pf_refetch", CPU_RDVALID, RB);
        drd();
        chk("pf_do", CPU_DO, RB ? 16'h1234 : 16'h0000);
        chk("pf_addr", CPU_ADDR, RB ? 9'h000 : 9'h1FF);

        // Write beats read; address load beats write
        cyc(0, '0, 0, 1, 1, 16'h2222);
        cyc(0, '0, 1, 1, 0, 16'h0030);
        chk("awr_wins", CPU_ADDR, 9'h030);
        idle(2);
        vid(RB ? 9'h000 : 9'h1FF);
        idle(1);
        chk("wr_beats_rd", VID_COLOR, 16'h2222);
        drd();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
